// File: rtl/result_collector.sv
// Captures PE-array tile results on each rising edge of done into a first-word-fall-through FIFO.
// Optional importance tracker (highest importance seen and its tile index) enabled by IMPORTANCE_TRACK_EN.
module result_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       _reset,
  input  logic                       clear,
  input  logic                       done,
  input  logic [2*WIDTH-1:0]         result0,
  input  logic [2*WIDTH-1:0]         result1,
  input  logic [2*WIDTH-1:0]         result2,
  input  logic [2*WIDTH-1:0]         result3,
  input  logic [2*WIDTH-1:0]         importance,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [8*WIDTH-1:0]         out_data,
  output logic [2*WIDTH-1:0]         out_importance,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [7:0]                 tile_count,
  output logic                       max_valid,
  output logic [2*WIDTH-1:0]         max_importance,
  output logic [7:0]                 max_index
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic                done_q, done_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          tile_count_q, tile_count_d;

  logic                capture;
  logic                pop;
  logic                push;
  logic                drop;

  // Storage is intentionally left without reset; contents only matter while out_valid is high.
  logic [8*WIDTH-1:0]  data_mem [DEPTH];
  logic [2*WIDTH-1:0]  imp_mem  [DEPTH];

  assign out_valid      = (count_q != '0);
  assign full           = (count_q == DEPTH_C);
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign tile_count     = tile_count_q;
  assign out_data       = data_mem[rd_ptr_q];
  assign out_importance = imp_mem[rd_ptr_q];

  always_comb begin
    capture = done & ~done_q;
    pop     = out_valid & out_ready;
    // A full FIFO can still take a tile when the head leaves in the same cycle.
    push    = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  always_comb begin
    done_d       = done;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    tile_count_d = tile_count_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      tile_count_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        tile_count_d = tile_count_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      tile_count_q <= '0;
    end else begin
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      tile_count_q <= tile_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      data_mem[wr_ptr_q] <= {result3, result2, result1, result0};
      imp_mem[wr_ptr_q]  <= importance;
    end
  end

`ifdef IMPORTANCE_TRACK_EN
  logic                max_valid_q, max_valid_d;
  logic [2*WIDTH-1:0]  max_imp_q, max_imp_d;
  logic [7:0]          max_index_q, max_index_d;

  always_comb begin
    max_valid_d = max_valid_q;
    max_imp_d   = max_imp_q;
    max_index_d = max_index_q;
    if (clear) begin
      max_valid_d = 1'b0;
      max_imp_d   = '0;
      max_index_d = '0;
    end else if (push) begin
      // Strict compare: ties keep the earliest tile's index.
      if (!max_valid_q || ($signed(importance) > $signed(max_imp_q))) begin
        max_imp_d   = importance;
        max_index_d = tile_count_q;
      end
      max_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      max_valid_q <= 1'b0;
      max_imp_q   <= '0;
      max_index_q <= '0;
    end else begin
      max_valid_q <= max_valid_d;
      max_imp_q   <= max_imp_d;
      max_index_q <= max_index_d;
    end
  end

  assign max_valid      = max_valid_q;
  assign max_importance = max_imp_q;
  assign max_index      = max_index_q;
`else
  assign max_valid      = 1'b0;
  assign max_importance = '0;
  assign max_index      = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (WIDTH=8, DEPTH=4); expectations follow IMPORTANCE_TRACK_EN.
module tb_result_collector;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        done;
  logic [15:0] r0, r1, r2, r3, imp;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [15:0] out_importance;
  logic [2:0]  count;
  logic        full;
  logic        overflow;
  logic [7:0]  tile_count;
  logic        max_valid;
  logic [15:0] max_importance;
  logic [7:0]  max_index;

  int checks = 0;
  int errors = 0;

  result_collector #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), ._reset(reset_n), .clear(clear), .done(done),
    .result0(r0), .result1(r1), .result2(r2), .result3(r3),
    .importance(imp), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_importance(out_importance), .count(count),
    .full(full), .overflow(overflow), .tile_count(tile_count),
    .max_valid(max_valid), .max_importance(max_importance), .max_index(max_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] tile_data(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  task automatic pulse(input logic [15:0] base, input logic [15:0] im);
    r0 = base; r1 = base + 16'd1; r2 = base + 16'd2; r3 = base + 16'd3;
    imp = im;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; done = 1'b0; out_ready = 1'b0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; imp = '0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_tiles", 64'(tile_count), 64'd0);
    check("rst_maxv", 64'(max_valid), 64'd0);
    check("rst_maxi", 64'(max_importance), 64'd0);
    check("rst_maxx", 64'(max_index), 64'd0);
    reset_n = 1'b1;
    tick();

    // Held done captures exactly once.
    r0 = 16'h0004; r1 = 16'h0004; r2 = 16'h0004; r3 = 16'h0004; imp = 16'h0004;
    done = 1'b1;
    tick();
    check("latency_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    done = 1'b0;
    tick();
    check("held_count", 64'(count), 64'd1);
    check("held_tiles", 64'(tile_count), 64'd1);
    check("held_data", out_data, 64'h0004_0004_0004_0004);
    check("held_imp", 64'(out_importance), 64'h0004);
    pop_one();
    check("pop_empty", 64'(out_valid), 64'd0);
    do_clear();

    // Five tiles into a 4-deep FIFO with no consumer.
    pulse(16'h0100, 16'd5);
    pulse(16'h0200, 16'hFFFD);
    pulse(16'h0300, 16'd9);
    pulse(16'h0400, 16'd9);
    check("fill_ovf0", 64'(overflow), 64'd0);
    pulse(16'h0500, 16'd2);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_tiles", 64'(tile_count), 64'd4);
`ifdef IMPORTANCE_TRACK_EN
    check("max_valid", 64'(max_valid), 64'd1);
    check("max_imp", 64'(max_importance), 64'd9);
    check("max_idx", 64'(max_index), 64'd2);
`else
    check("max_valid_off", 64'(max_valid), 64'd0);
    check("max_imp_off", 64'(max_importance), 64'd0);
    check("max_idx_off", 64'(max_index), 64'd0);
`endif
    check("ord0_data", out_data, tile_data(16'h0100));
    check("ord0_imp", 64'(out_importance), 64'd5);
    pop_one();
    check("ord1_data", out_data, tile_data(16'h0200));
    check("ord1_imp", 64'(out_importance), 64'hFFFD);
    pop_one();
    check("ord2_data", out_data, tile_data(16'h0300));
    pop_one();
    check("ord3_data", out_data, tile_data(16'h0400));
    pop_one();
    check("drained_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("underflow_count", 64'(count), 64'd0);
    check("sticky_ovf", 64'(overflow), 64'd1);
    do_clear();
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_maxv", 64'(max_valid), 64'd0);

    // Full FIFO: capture coincident with pop is accepted.
    pulse(16'h1000, 16'd1);
    pulse(16'h2000, 16'd2);
    pulse(16'h3000, 16'd3);
    pulse(16'h4000, 16'd4);
    r0 = 16'h5000; r1 = 16'h5001; r2 = 16'h5002; r3 = 16'h5003; imp = 16'd10;
    done = 1'b1; out_ready = 1'b1;
    tick();
    done = 1'b0; out_ready = 1'b0;
    check("sim_count", 64'(count), 64'd4);
    check("sim_ovf", 64'(overflow), 64'd0);
    check("sim_tiles", 64'(tile_count), 64'd5);
    check("sim_head", out_data, tile_data(16'h2000));
`ifdef IMPORTANCE_TRACK_EN
    check("sim_maxi", 64'(max_importance), 64'd10);
    check("sim_maxx", 64'(max_index), 64'd4);
`else
    check("sim_maxi_off", 64'(max_importance), 64'd0);
`endif
    pop_one();
    check("wrap1_imp", 64'(out_importance), 64'd3);
    pop_one();
    check("wrap2_imp", 64'(out_importance), 64'd4);
    pop_one();
    check("wrap3_data", out_data, tile_data(16'h5000));
    check("wrap3_imp", 64'(out_importance), 64'd10);
    do_clear();

    // Clear wins over a same-cycle capture; held done does not recapture afterwards.
    pulse(16'h0A00, 16'd7);
    pulse(16'h0B00, 16'd8);
    check("pre_clr_count", 64'(count), 64'd2);
    done = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", 64'(count), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_tiles", 64'(tile_count), 64'd0);
    tick();
    done = 1'b0;
    check("clr_noreacq", 64'(count), 64'd0);
    tick();

    // Asynchronous reset mid-stream.
    pulse(16'h0C00, 16'd1);
    pulse(16'h0D00, 16'd2);
    pulse(16'h0E00, 16'd3);
    check("pre_rst_count", 64'(count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_tiles", 64'(tile_count), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    check("arst_maxv", 64'(max_valid), 64'd0);
    #3 reset_n = 1'b1;
    tick();
    check("post_rst_count", 64'(count), 64'd0);

    // tile_count wraps 255 -> 0 with a consumer draining each tile.
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) pulse(16'(i), 16'd0);
    check("tiles_255", 64'(tile_count), 64'd255);
    pulse(16'h00FF, 16'd0);
    check("tiles_wrap", 64'(tile_count), 64'd0);
    check("wrap_drained", 64'(count), 64'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
